bsg_dram_channel_fixed_latency_model: RTL and testbench

//  Single-channel DRAM responder speaking the dramsim3 per-channel protocol: req v/yumi, write data v/yumi, read data v.

---
 rtl/bsg_dram_channel_fixed_latency_model.sv | 184 ++++++++++++++++++
 tb/tb_bsg_dram_channel_fixed_latency_model.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_dram_channel_fixed_latency_model.sv
// bsg_dram_channel_fixed_latency_model
//
// Deterministic single-channel DRAM responder that speaks the dramsim3
// per-channel handshake. It stands in for one dramsim3 channel behind
// bsg_cache_to_ramulator_hbm. Every read returns after exactly latency_p cycles.
// A periodic refresh blackout blocks new requests for refresh_cycles_p cycles
// out of every refresh_interval_p + refresh_cycles_p cycles, so bandwidth
// tests see a predictable baseline.
//
// Ports
//   clk_i            : clock
//   reset_i          : asynchronous, active-high reset
//   v_i              : request valid
//   write_not_read_i : 1 = write request, 0 = read request
//   ch_addr_i        : byte address within the channel
//   yumi_o           : request accepted this cycle (combinational)
//   data_v_i         : write data valid
//   data_i           : write data beat
//   data_yumi_o      : write data consumed this cycle (combinational)
//   data_v_o         : read data valid, one-cycle pulse with no backpressure
//   data_o           : read data; holds the last returned beat between pulses
//   read_count_o     : reads accepted since reset (wraps at 32 bits)
//   write_count_o    : writes accepted since reset (wraps at 32 bits)

module bsg_dram_channel_fixed_latency_model #(
  parameter int channel_addr_width_p = 29,
  parameter int data_width_p         = 256,
  parameter int mem_els_p            = 4096,
  parameter int latency_p            = 16,
  parameter int refresh_interval_p   = 1024,
  parameter int refresh_cycles_p     = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            v_i,
  input  logic                            write_not_read_i,
  input  logic [channel_addr_width_p-1:0] ch_addr_i,
  output logic                            yumi_o,
  input  logic                            data_v_i,
  input  logic [data_width_p-1:0]         data_i,
  output logic                            data_yumi_o,
  output logic                            data_v_o,
  output logic [data_width_p-1:0]         data_o,
  output logic [31:0]                     read_count_o,
  output logic [31:0]                     write_count_o
);

  localparam int lg_beat_bytes = $clog2(data_width_p / 8);
  localparam int lg_mem_els    = $clog2(mem_els_p);

  typedef enum logic {
    NORMAL,
    REFRESH
  } state_e;

  state_e      state;
  logic [31:0] refresh_count;

  logic [lg_mem_els-1:0]   index;
  logic [data_width_p-1:0] mem [mem_els_p];

  logic in_normal;
  logic write_accept;
  logic read_accept;

  // The byte-offset bits below the beat and any bits above the array size
  // are ignored. Higher addresses alias onto the same beats.
  assign index = ch_addr_i[lg_beat_bytes +: lg_mem_els];

  // Every address bit is folded in so that the ignored bits are visibly
  // consumed. The aliasing is intentional.
  logic unused_addr;
  assign unused_addr = ^ch_addr_i;

  // Accept is combinational and is suppressed while reset is held, so the
  // handshake outputs read 0 for the whole reset window.
  assign in_normal    = (state == NORMAL) && !reset_i;
  assign write_accept = in_normal && v_i && write_not_read_i && data_v_i;
  assign read_accept  = in_normal && v_i && !write_not_read_i;
  assign yumi_o       = write_accept || read_accept;
  assign data_yumi_o  = write_accept;

  // Refresh scheduler. In NORMAL the counter counts cycles up to
  // refresh_interval_p-1. Then the FSM spends refresh_cycles_p cycles in
  // REFRESH and comes back with the counter cleared. An interval of 0 turns
  // refresh off. A zero-length blackout never leaves NORMAL.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= NORMAL;
      refresh_count <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (refresh_interval_p == 0) begin
            refresh_count <= '0;
          end else if (refresh_count == 32'(refresh_interval_p - 1)) begin
            refresh_count <= '0;
            if (refresh_cycles_p != 0) state <= REFRESH;
          end else begin
            refresh_count <= refresh_count + 32'd1;
          end
        end
        REFRESH: begin
          if (refresh_count == 32'(refresh_cycles_p - 1)) begin
            state         <= NORMAL;
            refresh_count <= '0;
          end else begin
            refresh_count <= refresh_count + 32'd1;
          end
        end
        default: begin
          state         <= NORMAL;
          refresh_count <= '0;
        end
      endcase
    end
  end

  // Backing store. Reset does not clear it. A write becomes visible at the
  // edge that accepts it.
  always_ff @(posedge clk_i) begin
    if (write_accept) mem[index] <= data_i;
  end

  // Read return delay line. Stage 0 captures the array contents at the
  // accept edge, which is the snapshot point. Each later stage copies the
  // stage before it. The last stage drives the outputs. Its data updates
  // only when a valid beat arrives, so data_o keeps the last returned beat.
  logic [latency_p-1:0]    pipe_v;
  logic [data_width_p-1:0] pipe_d  [latency_p];
  logic [latency_p-1:0]    chain_v;
  logic [data_width_p-1:0] chain_d [latency_p];

  always_comb begin
    chain_v[0] = read_accept;
    chain_d[0] = mem[index];
    for (int i = 1; i < latency_p; i++) begin
      chain_v[i] = pipe_v[i-1];
      chain_d[i] = pipe_d[i-1];
    end
  end

  // Reset clears every valid bit, so any reads still in flight are dropped.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pipe_v <= '0;
      for (int i = 0; i < latency_p; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v <= chain_v;
      for (int i = 0; i < latency_p; i++) begin
        if ((i != latency_p - 1) || chain_v[i]) pipe_d[i] <= chain_d[i];
      end
    end
  end

  assign data_v_o = pipe_v[latency_p-1];
  assign data_o   = pipe_d[latency_p-1];

  // Accept counters. They wrap naturally at 32 bits.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      read_count_o  <= '0;
      write_count_o <= '0;
    end else begin
      if (read_accept)  read_count_o  <= read_count_o + 32'd1;
      if (write_accept) write_count_o <= write_count_o + 32'd1;
    end
  end

  // Simulation-only sanity checks on the configuration and on write data.
  always @(posedge clk_i) begin
    assert (latency_p >= 1)
      else $error("latency_p must be at least 1");
    assert ((mem_els_p & (mem_els_p - 1)) == 0)
      else $error("mem_els_p must be a power of 2");
    assert ((refresh_interval_p == 0) || (refresh_cycles_p < refresh_interval_p))
      else $error("refresh_cycles_p must be below refresh_interval_p");
    if (!reset_i && write_accept) begin
      assert (!$isunknown(data_i))
        else $error("accepted write carries X data");
    end
  end

endmodule

// File: tb/tb_bsg_dram_channel_fixed_latency_model.sv
// Self-checking bench for bsg_dram_channel_fixed_latency_model.
// The reference keeps a beat array and a queue of time-stamped returns. It
// derives the refresh blackout from the cycle number since reset.
module tb_bsg_dram_channel_fixed_latency_model;

  localparam int AW        = 29;
  localparam int DW        = 256;
  localparam int LATENCY   = 16;
  localparam int INTERVAL  = 1024;
  localparam int BLACKOUT  = 8;
  localparam int PERIOD    = INTERVAL + BLACKOUT;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          v_i = 1'b0;
  logic          write_not_read_i = 1'b0;
  logic [AW-1:0] ch_addr_i = '0;
  logic          yumi_o;
  logic          data_v_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          data_yumi_o;
  logic          data_v_o;
  logic [DW-1:0] data_o;
  logic [31:0]   read_count_o;
  logic [31:0]   write_count_o;

  bsg_dram_channel_fixed_latency_model dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .v_i              (v_i),
    .write_not_read_i (write_not_read_i),
    .ch_addr_i        (ch_addr_i),
    .yumi_o           (yumi_o),
    .data_v_i         (data_v_i),
    .data_i           (data_i),
    .data_yumi_o      (data_yumi_o),
    .data_v_o         (data_v_o),
    .data_o           (data_o),
    .read_count_o     (read_count_o),
    .write_count_o    (write_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } ret_t;

  logic [DW-1:0] mem_m [4096];
  ret_t          ret_q [$];
  logic [DW-1:0] last_d;
  logic [31:0]   rd_cnt;
  logic [31:0]   wr_cnt;
  int            cycle;
  int            errors;
  int            checks;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%h exp=%h", tag, cycle, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] makeAddr(input int beat);
    logic [11:0] hi;
    logic [11:0] b;
    logic [4:0]  lo;
    hi = 12'($urandom);
    b  = 12'(beat);
    lo = 5'($urandom);
    return {hi[11:0], b, lo};
  endfunction

  function automatic logic [DW-1:0] randBeat();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle: drive the inputs, compare against the reference mid-cycle,
  // then advance the reference at the clock edge. Entered and left at a negedge.
  task automatic applyStimulus(input logic v, input logic wnr, input logic [AW-1:0] addr,
                               input logic dv, input logic [DW-1:0] d);
    logic blackout, exp_y, exp_dy, exp_dv;
    logic [DW-1:0] exp_do;
    int idx;
    v_i = v; write_not_read_i = wnr; ch_addr_i = addr; data_v_i = dv; data_i = d;
    #1;
    idx      = int'(addr[16:5]);
    blackout = (cycle % PERIOD) >= INTERVAL;
    exp_y    = v && !blackout && (!wnr || dv);
    exp_dy   = exp_y && wnr;
    exp_dv   = (ret_q.size() != 0) && (ret_q[0].due == cycle);
    exp_do   = exp_dv ? ret_q[0].d : last_d;
    checkOutput("yumi", DW'(yumi_o), DW'(exp_y));
    checkOutput("data_yumi", DW'(data_yumi_o), DW'(exp_dy));
    checkOutput("data_v", DW'(data_v_o), DW'(exp_dv));
    checkOutput("data_o", data_o, exp_do);
    checkOutput("read_count", DW'(read_count_o), DW'(rd_cnt));
    checkOutput("write_count", DW'(write_count_o), DW'(wr_cnt));
    if (exp_dv) begin
      last_d = ret_q[0].d;
      void'(ret_q.pop_front());
    end
    @(posedge clk_i);
    if (exp_y && !wnr) begin
      ret_q.push_back('{due: cycle + LATENCY, d: mem_m[idx]});
      rd_cnt++;
    end
    if (exp_dy) begin
      mem_m[idx] = d;
      wr_cnt++;
    end
    cycle++;
    @(negedge clk_i);
  endtask

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Reset is asserted mid-cycle with a read request pending. Everything
  // visible must drop to zero immediately.
  task automatic doReset();
    reset_i = 1'b1;
    v_i = 1'b1; write_not_read_i = 1'b0; ch_addr_i = makeAddr(3); data_v_i = 1'b1; data_i = '0;
    #1;
    checkOutput("rst_yumi", DW'(yumi_o), '0);
    checkOutput("rst_data_yumi", DW'(data_yumi_o), '0);
    checkOutput("rst_data_v", DW'(data_v_o), '0);
    checkOutput("rst_data_o", data_o, '0);
    checkOutput("rst_read_count", DW'(read_count_o), '0);
    checkOutput("rst_write_count", DW'(write_count_o), '0);
    ret_q.delete();
    rd_cnt = '0;
    wr_cnt = '0;
    last_d = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    v_i = 1'b0; data_v_i = 1'b0;
    reset_i = 1'b0;
    cycle = 0;
  endtask

  initial begin
    logic [DW-1:0] beat_a, beat_b;
    errors = 0;
    checks = 0;
    cycle  = 0;
    @(negedge clk_i);
    doReset();

    // Write A to 0x40, then read it back. Its return is due 16 cycles later.
    beat_a = randBeat();
    applyStimulus(1'b1, 1'b1, 29'h40, 1'b1, beat_a);
    applyStimulus(1'b1, 1'b0, 29'h40, 1'b0, '0);
    idleCycles(LATENCY + 1);

    // Preload beats 0..31 through aliasing addresses. Beats 0..15 hold the value k.
    for (int k = 0; k < 32; k++)
      applyStimulus(1'b1, 1'b1, makeAddr(k), 1'b1, (k < 16) ? DW'(k) : randBeat());

    // Sixteen back-to-back reads give sixteen back-to-back returns.
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, makeAddr(k), 1'b0, '0);
    idleCycles(LATENCY + 1);

    // A write with no data stalls until data_v_i arrives. Data alone is never consumed.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, makeAddr(20), 1'b0, randBeat());
    applyStimulus(1'b1, 1'b1, makeAddr(20), 1'b1, randBeat());
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, makeAddr(21), 1'b1, randBeat());

    // Read, then overwrite the same beat. The read must return the old value.
    beat_b = randBeat();
    applyStimulus(1'b1, 1'b0, 29'h40, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 29'h40, 1'b1, beat_b);
    idleCycles(LATENCY + 1);

    // Random traffic over the preloaded beats.
    for (int k = 0; k < 200; k++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), makeAddr($urandom_range(0, 31)),
                    1'($urandom_range(0, 3) != 0), randBeat());

    // Continuous reads across the first refresh blackout.
    while (cycle < INTERVAL + BLACKOUT + 30)
      applyStimulus(1'b1, 1'b0, makeAddr($urandom_range(0, 31)), 1'b0, '0);
    idleCycles(LATENCY + 1);

    // Reset with five reads in flight. Those reads are dropped, and a fresh read still works.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, makeAddr(k + 8), 1'b0, '0);
    doReset();
    idleCycles(LATENCY + 4);
    applyStimulus(1'b1, 1'b0, makeAddr(5), 1'b0, '0);
    idleCycles(LATENCY + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
